// File: rtl/sw_evt_trig_pkg.sv
// Shared types and constants for the software-event trigger initiator.
package sw_evt_trig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Entry fields are sized for the widest supported configuration; narrower ids/masks are zero-extended.
    localparam int ENTRY_EVT_W  = 16;
    localparam int ENTRY_MASK_W = 32;

    typedef struct packed {
        logic [ENTRY_EVT_W-1:0]  evt;
        logic [ENTRY_MASK_W-1:0] mask;
    } trig_entry_t;

    localparam logic       WEN_WRITE = 1'b0;
    localparam logic [3:0] BE_ALL    = 4'hF;

    function automatic int evt_w(input int nb_evt);
        return (nb_evt > 1) ? $clog2(nb_evt) : 1;
    endfunction

endpackage

// File: rtl/sw_evt_trig_fifo.sv
// Synchronous FIFO of trigger entries; pointers carry one extra wrap bit to tell full from empty.
module sw_evt_trig_fifo
    import sw_evt_trig_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  trig_entry_t i_data,
    input  logic        i_pop,
    output trig_entry_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = (AW+1)'(1);

    trig_entry_t r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/sw_evt_trig_initiator.sv
// Buffers software-event trigger requests and issues one single-beat write per request
// to the trigger slave at BASE_ADDR + 4*evt with the core mask as write data.
module sw_evt_trig_initiator
    import sw_evt_trig_pkg::*;
#(
    parameter int          NB_CORES   = 4,
    parameter int          NB_SW_EVT  = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ID_W       = 5,
    localparam int         EVT_W      = evt_w(NB_SW_EVT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                trig_valid_i,
    output logic                trig_ready_o,
    input  logic [EVT_W-1:0]    trig_evt_i,
    input  logic [NB_CORES-1:0] trig_mask_i,
    output logic                periph_req_o,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_wdata_o,
    output logic [ID_W-1:0]     periph_id_o,
    input  logic                periph_gnt_i,
    input  logic                periph_r_valid_i,
    output logic                busy_o,
    output logic [15:0]         issued_cnt_o,
    output logic [7:0]          dropped_cnt_o
);

    // state | meaning
    // IDLE  | no transaction; pops the FIFO head when one is available
    // REQ   | request on the bus with stable add/wdata, waiting for grant
    // RESP  | granted, waiting for r_valid; pops the next entry straight into REQ

    state_t      r_state;
    state_t      w_state_nxt;
    trig_entry_t w_push_entry;
    trig_entry_t w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic        w_rsp_done;
    logic [31:0] r_add;
    logic [31:0] r_wdata;
    logic [15:0] r_issued;
    logic [7:0]  r_dropped;

    assign trig_ready_o = !w_full;
    assign w_accept     = trig_valid_i && !w_full;
    // A zero mask would be decoded by the slave as a broadcast, so it never reaches the bus.
    assign w_push       = w_accept && (trig_mask_i != '0);
    assign w_drop       = w_accept && (trig_mask_i == '0);

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.evt  = ENTRY_EVT_W'(trig_evt_i);
        w_push_entry.mask = ENTRY_MASK_W'(trig_mask_i);
    end

    sw_evt_trig_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_state_nxt = REQ;
            REQ:     if (periph_gnt_i) w_state_nxt = RESP;
            RESP:    if (w_rsp_done) w_state_nxt = w_pop ? REQ : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        periph_req_o = (r_state == REQ);
        w_rsp_done   = (r_state == RESP) && periph_r_valid_i;
        w_pop        = !w_empty && ((r_state == IDLE) || w_rsp_done);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_add   <= '0;
            r_wdata <= '0;
        end else if (w_pop) begin
            r_add   <= BASE_ADDR + (32'(w_head.evt) << 2);
            r_wdata <= w_head.mask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_issued  <= '0;
            r_dropped <= '0;
        end else begin
            if (w_rsp_done) r_issued <= r_issued + 16'd1;
            if (w_drop && (r_dropped != 8'hFF)) r_dropped <= r_dropped + 8'd1;
        end
    end

    assign periph_add_o   = r_add;
    assign periph_wdata_o = r_wdata;
    assign periph_wen_o   = WEN_WRITE;
    assign periph_be_o    = BE_ALL;
    assign periph_id_o    = '0;
    assign busy_o         = !w_empty || (r_state != IDLE);
    assign issued_cnt_o   = r_issued;
    assign dropped_cnt_o  = r_dropped;

endmodule

// File: tb/tb_sw_evt_trig_initiator.sv
// Directed bench for sw_evt_trig_initiator: a request-level model of accepted triggers is
// checked against the bus every cycle, and literal expectations pin timing and addresses.
module tb_sw_evt_trig_initiator;

    localparam int          NB_CORES   = 4;
    localparam int          NB_SW_EVT  = 8;
    localparam int          FIFO_DEPTH = 4;
    localparam int          ID_W       = 5;
    localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            trig_valid = 1'b0;
    logic [2:0]      trig_evt = '0;
    logic [3:0]      trig_mask = '0;
    logic            trig_ready;
    logic            periph_req;
    logic [31:0]     periph_add;
    logic            periph_wen;
    logic [3:0]      periph_be;
    logic [31:0]     periph_wdata;
    logic [ID_W-1:0] periph_id;
    logic            periph_gnt;
    logic            periph_r_valid;
    logic            busy;
    logic [15:0]     issued_cnt;
    logic [7:0]      dropped_cnt;

    logic gnt_en = 1'b0;
    logic rvalid_auto = 1'b0;
    logic rvalid_force = 1'b0;

    always #5 clk = ~clk;

    sw_evt_trig_initiator #(
        .NB_CORES   (NB_CORES),
        .NB_SW_EVT  (NB_SW_EVT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (BASE_ADDR),
        .ID_W       (ID_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .trig_valid_i     (trig_valid),
        .trig_ready_o     (trig_ready),
        .trig_evt_i       (trig_evt),
        .trig_mask_i      (trig_mask),
        .periph_req_o     (periph_req),
        .periph_add_o     (periph_add),
        .periph_wen_o     (periph_wen),
        .periph_be_o      (periph_be),
        .periph_wdata_o   (periph_wdata),
        .periph_id_o      (periph_id),
        .periph_gnt_i     (periph_gnt),
        .periph_r_valid_i (periph_r_valid),
        .busy_o           (busy),
        .issued_cnt_o     (issued_cnt),
        .dropped_cnt_o    (dropped_cnt)
    );

    // Slave: grant while enabled, respond one cycle after the grant.
    assign periph_gnt     = periph_req & gnt_en;
    assign periph_r_valid = rvalid_auto | rvalid_force;
    always @(posedge clk) rvalid_auto <= periph_req && periph_gnt && !rst_i;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Request-level model: triggers not yet granted, whether one write is outstanding, counters.
    typedef struct {
        int evt;
        int mask;
    } ent_t;

    ent_t        m_q[$];
    bit          m_out = 1'b0;
    int          m_issued = 0;
    int          m_dropped = 0;
    bit          armed = 1'b0;
    int          gnt_cyc[$];
    logic [31:0] wr_add[$];
    logic [31:0] wr_data[$];
    int          req_cycles = 0;

    always @(negedge clk) begin
        int pending;
        pending = m_q.size() + (m_out ? 1 : 0);
        if (armed) begin
            if (pending < FIFO_DEPTH)      chk("ready_not_full", 32'(trig_ready), 32'd1);
            else if (pending > FIFO_DEPTH) chk("ready_full", 32'(trig_ready), 32'd0);
            chk("busy", 32'(busy), 32'(pending > 0));
            chk("issued_cnt", 32'(issued_cnt), 32'(m_issued % 65536));
            chk("dropped_cnt", 32'(dropped_cnt), 32'(m_dropped));
            if (periph_req) begin
                req_cycles++;
                chk("single_outstanding", 32'(m_out), 32'd0);
                chk("req_has_trigger", 32'(m_q.size() != 0), 32'd1);
                if (m_q.size() != 0) begin
                    chk("add", periph_add, BASE_ADDR + 32'(4 * m_q[0].evt));
                    chk("wdata", periph_wdata, 32'(m_q[0].mask));
                end
                chk("wen", 32'(periph_wen), 32'd0);
                chk("be", 32'(periph_be), 32'hF);
                chk("id", 32'(periph_id), 32'd0);
            end
        end
        if (rst_i) begin
            m_q.delete();
            m_out     = 1'b0;
            m_issued  = 0;
            m_dropped = 0;
            armed     = 1'b1;
        end else begin
            if (periph_r_valid && m_out) begin
                m_out = 1'b0;
                m_issued++;
            end
            if (periph_req && periph_gnt) begin
                gnt_cyc.push_back(cyc);
                wr_add.push_back(periph_add);
                wr_data.push_back(periph_wdata);
                if (m_q.size() != 0) void'(m_q.pop_front());
                m_out = 1'b1;
            end
            if (trig_valid && trig_ready) begin
                if (trig_mask == 4'd0) begin
                    if (m_dropped < 255) m_dropped++;
                end else begin
                    m_q.push_back('{evt: int'(trig_evt), mask: int'(trig_mask)});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int evt, input int mask);
        bit done;
        done       = 1'b0;
        trig_valid = 1'b1;
        trig_evt   = 3'(evt);
        trig_mask  = 4'(mask);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = trig_ready;
            tick();
        end
        trig_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: got ready=0 for 100 cycles expected acceptance");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = !busy;
        end
        tick();
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: got busy=1 for 300 cycles expected idle");
        end
    endtask

    task automatic wait_req(output int c);
        bit done;
        done = 1'b0;
        c    = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = periph_req;
            c    = cyc;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_timeout: got req=0 for 100 cycles expected req");
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int g0;
        int rc0;
        int t0;
        int r;

        tick();
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(periph_req), 32'd0);
        chk("rst_add", periph_add, 32'd0);
        chk("rst_wdata", periph_wdata, 32'd0);
        chk("rst_ready", 32'(trig_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_issued", 32'(issued_cnt), 32'd0);
        chk("rst_dropped", 32'(dropped_cnt), 32'd0);
        tick();

        // Single trigger with a zero-wait slave.
        gnt_en = 1'b1;
        g0  = gnt_cyc.size();
        rc0 = req_cycles;
        t0  = cyc;
        push(3, 4'b0101);
        wait_idle();
        chk("t1_write_count", 32'(gnt_cyc.size() - g0), 32'd1);
        if (gnt_cyc.size() > g0) begin
            chk("t1_req_latency", 32'(gnt_cyc[g0] - t0), 32'd2);
            chk("t1_add", wr_add[g0], 32'h0000_000C);
            chk("t1_wdata", wr_data[g0], 32'h0000_0005);
        end
        chk("t1_req_cycles", 32'(req_cycles - rc0), 32'd1);
        chk("t1_issued", 32'(issued_cnt), 32'd1);

        // Five back-to-back triggers with the grant held off.
        gnt_en = 1'b0;
        g0 = gnt_cyc.size();
        push(0, 4'h1);
        push(1, 4'h2);
        push(2, 4'h4);
        push(3, 4'h8);
        push(4, 4'hF);
        @(negedge clk);
        chk("t2_ready_low", 32'(trig_ready), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        gnt_en = 1'b1;
        wait_idle();
        chk("t2_write_count", 32'(gnt_cyc.size() - g0), 32'd5);
        if (gnt_cyc.size() >= g0 + 5) begin
            for (int i = 0; i < 5; i++) chk("t2_order_add", wr_add[g0 + i], 32'(4 * i));
            for (int i = 0; i < 4; i++) chk("t2_spacing", 32'(gnt_cyc[g0 + i + 1] - gnt_cyc[g0 + i]), 32'd2);
        end
        chk("t2_issued", 32'(issued_cnt), 32'd6);

        // Zero-mask requests are counted and dropped.
        do_reset();
        g0 = gnt_cyc.size();
        push(1, 4'h2);
        push(2, 4'h0);
        push(5, 4'h9);
        wait_idle();
        chk("t3_dropped", 32'(dropped_cnt), 32'd1);
        chk("t3_issued", 32'(issued_cnt), 32'd2);
        chk("t3_write_count", 32'(gnt_cyc.size() - g0), 32'd2);
        if (gnt_cyc.size() >= g0 + 2) begin
            chk("t3_add0", wr_add[g0], 32'h0000_0004);
            chk("t3_add1", wr_add[g0 + 1], 32'h0000_0014);
            chk("t3_wdata1", wr_data[g0 + 1], 32'h0000_0009);
        end
        for (int i = 0; i < 255; i++) push(i % 8, 0);
        @(negedge clk);
        chk("t3_dropped_sat", 32'(dropped_cnt), 32'hFF);
        tick();

        // Stray response while idle is ignored.
        rvalid_force = 1'b1;
        tick();
        rvalid_force = 1'b0;
        tick();
        @(negedge clk);
        chk("t3_stray_rvalid", 32'(issued_cnt), 32'd2);
        tick();

        // Grant delayed three cycles; next request waits for the response.
        gnt_en = 1'b0;
        g0  = gnt_cyc.size();
        rc0 = req_cycles;
        push(6, 4'h3);
        push(7, 4'hC);
        wait_req(r);
        tick();
        tick();
        tick();
        gnt_en = 1'b1;
        wait_idle();
        chk("t4_req_cycles", 32'(req_cycles - rc0), 32'd5);
        chk("t4_write_count", 32'(gnt_cyc.size() - g0), 32'd2);
        if (gnt_cyc.size() >= g0 + 2) begin
            chk("t4_gnt_delay", 32'(gnt_cyc[g0] - r), 32'd3);
            chk("t4_second_gap", 32'(gnt_cyc[g0 + 1] - gnt_cyc[g0]), 32'd2);
            chk("t4_add1", wr_add[g0 + 1], 32'h0000_001C);
        end
        chk("t4_issued", 32'(issued_cnt), 32'd4);

        // Reset while a request is on the bus with two entries queued.
        gnt_en = 1'b0;
        push(1, 4'h1);
        push(2, 4'h2);
        push(3, 4'h3);
        wait_req(r);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("t5_req", 32'(periph_req), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_issued", 32'(issued_cnt), 32'd0);
        chk("t5_dropped", 32'(dropped_cnt), 32'd0);
        chk("t5_ready", 32'(trig_ready), 32'd1);
        tick();
        gnt_en = 1'b1;
        g0  = gnt_cyc.size();
        rc0 = req_cycles;
        repeat (20) tick();
        chk("t5_no_write", 32'(gnt_cyc.size() - g0), 32'd0);
        chk("t5_no_req", 32'(req_cycles - rc0), 32'd0);

        // Push coinciding with pop at occupancy one.
        g0 = gnt_cyc.size();
        t0 = cyc;
        push(0, 4'h1);
        push(1, 4'h2);
        tick();
        push(2, 4'h4);
        tick();
        push(3, 4'h8);
        tick();
        push(4, 4'h3);
        wait_idle();
        chk("t6_write_count", 32'(gnt_cyc.size() - g0), 32'd5);
        if (gnt_cyc.size() >= g0 + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t6_gnt_cycle", 32'(gnt_cyc[g0 + i] - t0), 32'(2 + 2 * i));
                chk("t6_order_add", wr_add[g0 + i], 32'(4 * i));
            end
        end
        chk("t6_issued", 32'(issued_cnt), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
